// File: rtl/fir_smpl_sequencer_if.sv
// Sample-in / tap-out bundle between the band sample source, the sequencer
// and the FIR coefficient/accumulate datapath.
interface fir_smpl_sequencer_if;
    logic        wrt_smpl;
    logic [15:0] lft_smpl;
    logic [15:0] rght_smpl;
    logic        sequencing;
    logic [15:0] lft_out;
    logic [15:0] rght_out;

    modport master (
        output wrt_smpl, lft_smpl, rght_smpl,
        input  sequencing, lft_out, rght_out
    );

    modport slave (
        input  wrt_smpl, lft_smpl, rght_smpl,
        output sequencing, lft_out, rght_out
    );
endinterface

// File: rtl/fir_smpl_sequencer.sv
// Per-band stereo sample queue: streams the TAPS newest samples, oldest first,
// after every write once full. Optional SEQ_PEND_SMPL_EN holds one write arriving mid-window.
module fir_smpl_sequencer #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int TAPS  = 1021
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fir_smpl_sequencer_if.slave  bus
);

    typedef enum logic {IDLE, SEQ} state_t;

    localparam logic [AW-1:0] TAPS_W   = AW'(TAPS);
    localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);

    state_t          state, state_nx;
    logic [AW-1:0]   new_ptr, new_ptr_nx;
    logic [AW-1:0]   old_ptr, old_ptr_nx;
    logic [AW-1:0]   rd_ptr, rd_ptr_nx;
    logic [AW-1:0]   cnt, cnt_nx;
    logic [AW-1:0]   tap_cnt, tap_cnt_nx;

    logic [31:0]     mem [DEPTH];
    logic [31:0]     rd_data;
    logic [31:0]     in_data;
    logic            commit;
    logic [31:0]     commit_data;

    assign in_data = {bus.lft_smpl, bus.rght_smpl};

`ifdef SEQ_PEND_SMPL_EN
    logic            pend, pend_nx;
    logic [31:0]     pend_data, pend_data_nx;

    // A pending sample goes first; a write landing on that same cycle is
    // parked behind it so neither sample is lost.
    always_comb begin
        pend_nx      = pend;
        pend_data_nx = pend_data;
        commit       = 1'b0;
        commit_data  = in_data;
        if (state == IDLE) begin
            if (pend) begin
                commit       = 1'b1;
                commit_data  = pend_data;
                pend_nx      = bus.wrt_smpl;
                if (bus.wrt_smpl) begin
                    pend_data_nx = in_data;
                end
            end else if (bus.wrt_smpl) begin
                commit = 1'b1;
            end
        end else if (bus.wrt_smpl) begin
            pend_nx      = 1'b1;
            pend_data_nx = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= 1'b0;
            pend_data <= '0;
        end else begin
            pend      <= pend_nx;
            pend_data <= pend_data_nx;
        end
    end
`else
    always_comb begin
        commit      = (state == IDLE) && bus.wrt_smpl;
        commit_data = in_data;
    end
`endif

    always_comb begin
        state_nx   = state;
        new_ptr_nx = new_ptr;
        old_ptr_nx = old_ptr;
        rd_ptr_nx  = rd_ptr;
        cnt_nx     = cnt;
        tap_cnt_nx = tap_cnt;
        case (state)
            IDLE: begin
                if (commit) begin
                    new_ptr_nx = new_ptr + 1'b1;
                    if (cnt < TAPS_W) begin
                        cnt_nx = cnt + 1'b1;
                    end else begin
                        old_ptr_nx = old_ptr + 1'b1;
                    end
                    if (cnt_nx == TAPS_W) begin
                        state_nx   = SEQ;
                        rd_ptr_nx  = old_ptr_nx;
                        tap_cnt_nx = '0;
                    end
                end
            end
            SEQ: begin
                rd_ptr_nx  = rd_ptr + 1'b1;
                tap_cnt_nx = tap_cnt + 1'b1;
                if (tap_cnt == LAST_TAP) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            new_ptr <= '0;
            old_ptr <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            tap_cnt <= '0;
        end else begin
            state   <= state_nx;
            new_ptr <= new_ptr_nx;
            old_ptr <= old_ptr_nx;
            rd_ptr  <= rd_ptr_nx;
            cnt     <= cnt_nx;
            tap_cnt <= tap_cnt_nx;
        end
    end

    // Sample storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (commit && (state == IDLE)) begin
            mem[new_ptr] <= commit_data;
        end
    end

    assign rd_data        = mem[rd_ptr];
    assign bus.sequencing = (state == SEQ);
    assign bus.lft_out    = (state == SEQ) ? rd_data[31:16] : '0;
    assign bus.rght_out   = (state == SEQ) ? rd_data[15:0]  : '0;

endmodule

// File: tb/tb_fir_smpl_sequencer.sv
// Self-checking bench for fir_smpl_sequencer in a small configuration; honours SEQ_PEND_SMPL_EN.
module tb_fir_smpl_sequencer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int TAPS  = 13;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fir_smpl_sequencer_if bus();

    fir_smpl_sequencer #(.DEPTH(DEPTH), .AW(AW), .TAPS(TAPS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: history of accepted samples; each accepted sample that
    // leaves TAPS samples in history queues a copy of that history as the window.
    logic [31:0] hist[$];
    logic [31:0] exp_stream[$];
    bit          busy;
    bit          cur_v;
    logic [31:0] cur_d;
    bit          pend_m;
    logic [31:0] pend_v_m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            exp_stream.delete();
            busy = 0; cur_v = 0; cur_d = '0; pend_m = 0; pend_v_m = '0;
        end else begin
            bit          acc;
            logic [31:0] v;
            logic [31:0] inv;
            inv = {bus.lft_smpl, bus.rght_smpl};
            acc = 0; v = inv;
`ifdef SEQ_PEND_SMPL_EN
            if (!busy) begin
                if (pend_m) begin
                    acc = 1; v = pend_v_m;
                    pend_m = bus.wrt_smpl;
                    if (bus.wrt_smpl) pend_v_m = inv;
                end else if (bus.wrt_smpl) begin
                    acc = 1;
                end
            end else if (bus.wrt_smpl) begin
                pend_m = 1; pend_v_m = inv;
            end
`else
            acc = !busy && bus.wrt_smpl;
`endif
            if (acc) begin
                hist.push_back(v);
                if (hist.size() > TAPS) void'(hist.pop_front());
                if (hist.size() == TAPS) exp_stream = hist;
            end
            if (exp_stream.size() > 0) begin
                cur_v = 1; cur_d = exp_stream.pop_front();
            end else begin
                cur_v = 0; cur_d = '0;
            end
            busy = cur_v;
        end
    end

    always @(negedge clk) begin
        logic [32:0] e;
        e = (rst_n && cur_v) ? {1'b1, cur_d} : 33'd0;
        check("scoreboard", {31'd0, bus.sequencing, bus.lft_out, bus.rght_out}, {31'd0, e});
    end

    task automatic do_write(input logic [15:0] l, input logic [15:0] r);
        @(posedge clk); #1;
        bus.wrt_smpl = 1'b1; bus.lft_smpl = l; bus.rght_smpl = r;
        @(posedge clk); #1;
        bus.wrt_smpl = 1'b0;
    endtask

    task automatic observe(input int max_cyc, output int len, output logic [15:0] first_l,
                           output logic [15:0] last_l, output logic [15:0] last_r, output bit saw);
        len = 0; first_l = '0; last_l = '0; last_r = '0; saw = 0;
        for (int c = 0; c < max_cyc; c++) begin
            if (bus.sequencing) begin
                if (len == 0) first_l = bus.lft_out;
                last_l = bus.lft_out;
                last_r = bus.rght_out;
                if (bus.lft_out == 16'd5000) saw = 1;
                len++;
            end else if (len > 0) begin
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          exp_len;
        logic [15:0] exp_first;
        logic [15:0] exp_last_l;
        logic [15:0] exp_last_r;
    } vec_t;

    vec_t tbl[20];

    initial begin
        int          len;
        logic [15:0] f, ll, lr;
        bit          saw;
        bit          timed_out;

        for (int i = 1; i <= 20; i++) begin
            tbl[i-1].l          = 16'(i);
            tbl[i-1].r          = 16'(0 - i);
            tbl[i-1].exp_len    = (i >= TAPS) ? TAPS : 0;
            tbl[i-1].exp_first  = (i >= TAPS) ? 16'(i - TAPS + 1) : 16'd0;
            tbl[i-1].exp_last_l = (i >= TAPS) ? 16'(i) : 16'd0;
            tbl[i-1].exp_last_r = (i >= TAPS) ? 16'(0 - i) : 16'd0;
        end

        bus.wrt_smpl = 1'b0; bus.lft_smpl = '0; bus.rght_smpl = '0;
        #1;
        check("reset_seq", {63'd0, bus.sequencing}, 64'd0);
        check("reset_lft", {48'd0, bus.lft_out}, 64'd0);
        check("reset_rght", {48'd0, bus.rght_out}, 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill, steady state and pointer wrap (20 writes through a 16-entry buffer)
        for (int k = 0; k < 20; k++) begin
            do_write(tbl[k].l, tbl[k].r);
            observe(TAPS + 3, len, f, ll, lr, saw);
            check($sformatf("tbl%0d_len", k), 64'(len), 64'(tbl[k].exp_len));
            if (tbl[k].exp_len > 0) begin
                check($sformatf("tbl%0d_first", k), {48'd0, f}, {48'd0, tbl[k].exp_first});
                check($sformatf("tbl%0d_last_l", k), {48'd0, ll}, {48'd0, tbl[k].exp_last_l});
                check($sformatf("tbl%0d_last_r", k), {48'd0, lr}, {48'd0, tbl[k].exp_last_r});
            end
        end

        // Write arriving 10 cycles into a window
        do_write(16'd21, 16'(0 - 21));
        repeat (10) begin @(posedge clk); #1; end
        check("ovl_in_window", {63'd0, bus.sequencing}, 64'd1);
        bus.wrt_smpl = 1'b1; bus.lft_smpl = 16'd5000; bus.rght_smpl = 16'(0 - 5000);
        @(posedge clk); #1;
        bus.wrt_smpl = 1'b0;
        timed_out = 1;
        for (int c = 0; c < 2 * TAPS; c++) begin
            if (!bus.sequencing) begin timed_out = 0; break; end
            @(posedge clk); #1;
        end
        check("ovl_window_end_timeout", {63'd0, timed_out}, 64'd0);
        observe(TAPS + 4, len, f, ll, lr, saw);
`ifdef SEQ_PEND_SMPL_EN
        check("ovl_pend_len", 64'(len), 64'(TAPS));
        check("ovl_pend_last", {48'd0, ll}, 64'd5000);
`else
        check("ovl_pend_len", 64'(len), 64'd0);
`endif
        do_write(16'd22, 16'(0 - 22));
        observe(TAPS + 3, len, f, ll, lr, saw);
        check("ovl_next_last", {48'd0, ll}, 64'd22);
`ifdef SEQ_PEND_SMPL_EN
        check("ovl_next_has5000", {63'd0, saw}, 64'd1);
        check("ovl_next_first", {48'd0, f}, 64'd11);
`else
        check("ovl_next_has5000", {63'd0, saw}, 64'd0);
        check("ovl_next_first", {48'd0, f}, 64'd10);
`endif

        // Random traffic, including writes that land inside windows
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            bus.wrt_smpl  = ($urandom_range(0, 9) == 0);
            bus.lft_smpl  = 16'($urandom);
            bus.rght_smpl = 16'($urandom);
        end
        @(posedge clk); #1;
        bus.wrt_smpl = 1'b0;
        repeat (3 * TAPS + 4) @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a window
        do_write(16'h1234, 16'h4321);
        repeat (3) begin @(posedge clk); #1; end
        check("mid_seq_active", {63'd0, bus.sequencing}, 64'd1);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_seq", {63'd0, bus.sequencing}, 64'd0);
        check("async_rst_lft", {48'd0, bus.lft_out}, 64'd0);
        check("async_rst_rght", {48'd0, bus.rght_out}, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int k = 0; k < TAPS; k++) begin
            do_write(16'(100 + k), 16'(200 + k));
            observe(TAPS + 3, len, f, ll, lr, saw);
            check($sformatf("refill%0d_len", k), 64'(len), (k == TAPS - 1) ? 64'(TAPS) : 64'd0);
            if (k == TAPS - 1) begin
                check("refill_first", {48'd0, f}, 64'd100);
                check("refill_last_r", {48'd0, lr}, 64'(200 + TAPS - 1));
            end
        end

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
